// File: rtl/game_sequencer.sv
// ============================================================================
// game_sequencer : round/game controller for the number-guessing datapath.
// Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module game_sequencer #(
   parameter int MAX_GUESSES = 5,
   parameter int NUM_ROUNDS  = 3,
   parameter int TIME_1D     = 30,
   parameter int TIME_2D     = 60,
   parameter int TIME_3D     = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       confirm,
   input  logic       sec_tick,
   input  logic [3:0] guess_d1,
   input  logic [3:0] guess_d2,
   input  logic [3:0] guess_d3,
   input  logic [3:0] target_d1,
   input  logic [3:0] target_d2,
   input  logic [3:0] target_d3,
   input  logic       target_valid,
   output logic       target_req,
   output logic [1:0] max_digits,
   output logic [1:0] round,
   output logic [2:0] guesses_left,
   output logic [6:0] timer,
   output logic [1:0] hint,
   output logic [1:0] win_lose
);

   localparam logic [2:0] C_GUESS_LOAD = 3'(MAX_GUESSES);
   localparam logic [1:0] C_LAST_ROUND = 2'(NUM_ROUNDS);
   localparam logic [6:0] C_TIME_1D    = 7'(TIME_1D);
   localparam logic [6:0] C_TIME_2D    = 7'(TIME_2D);
   localparam logic [6:0] C_TIME_3D    = 7'(TIME_3D);

   localparam logic [1:0] C_HINT_NONE = 2'b00;
   localparam logic [1:0] C_HINT_LOW  = 2'b01;
   localparam logic [1:0] C_HINT_HIGH = 2'b10;
   localparam logic [1:0] C_HINT_OK   = 2'b11;
   localparam logic [1:0] C_WL_PLAY   = 2'b00;
   localparam logic [1:0] C_WL_WIN    = 2'b01;
   localparam logic [1:0] C_WL_LOSE   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT_T  = 3'd2,
      S_PLAY    = 3'd3,
      S_CHECK   = 3'd4,
      S_RND_WON = 3'd5,
      S_WIN     = 3'd6,
      S_LOSE    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  round_q, round_d;
   logic [1:0]  max_digits_q, max_digits_d;
   logic [2:0]  guesses_left_q, guesses_left_d;
   logic [6:0]  timer_q, timer_d;
   logic [1:0]  hint_q, hint_d;
   logic [1:0]  win_lose_q, win_lose_d;
   logic        target_req_q, target_req_d;
   logic [11:0] target_q, target_d;
   logic [11:0] guess_q, guess_d;

   logic [11:0] w_mask;
   logic [11:0] w_guess_act;
   logic [11:0] w_target_act;
   logic [6:0]  w_time_load;
   logic [2:0]  w_guesses_dec;

   // Masking inactive digits to zero on both sides makes a plain unsigned
   // compare equivalent to a most-significant-active-digit-first compare.
   always_comb begin
      case (max_digits_q)
         2'd1:    w_mask = 12'h00F;
         2'd2:    w_mask = 12'h0FF;
         default: w_mask = 12'hFFF;
      endcase
      w_guess_act  = guess_q & w_mask;
      w_target_act = target_q & w_mask;
   end

   always_comb begin
      case (max_digits_q)
         2'd1:    w_time_load = C_TIME_1D;
         2'd2:    w_time_load = C_TIME_2D;
         default: w_time_load = C_TIME_3D;
      endcase
   end

   assign w_guesses_dec = (guesses_left_q != 3'd0) ? guesses_left_q - 3'd1 : 3'd0;

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      max_digits_d   = max_digits_q;
      guesses_left_d = guesses_left_q;
      timer_d        = timer_q;
      hint_d         = hint_q;
      win_lose_d     = win_lose_q;
      target_d       = target_q;
      guess_d        = guess_q;

      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               round_d      = 2'd1;
               max_digits_d = 2'd1;
               win_lose_d   = C_WL_PLAY;
               hint_d       = C_HINT_NONE;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_WAIT_T;
         end
         S_WAIT_T: begin
            if (target_valid) begin
               target_d       = {target_d3, target_d2, target_d1};
               timer_d        = w_time_load;
               guesses_left_d = C_GUESS_LOAD;
               hint_d         = C_HINT_NONE;
               state_d        = S_PLAY;
            end
         end
         S_PLAY: begin
            // An expiring timer wins over a same-cycle confirm.
            if (sec_tick && (timer_q == 7'd1)) begin
               timer_d    = 7'd0;
               win_lose_d = C_WL_LOSE;
               state_d    = S_LOSE;
            end else begin
               if (sec_tick && (timer_q != 7'd0)) begin
                  timer_d = timer_q - 7'd1;
               end
               if (confirm) begin
                  guess_d = {guess_d3, guess_d2, guess_d1};
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (w_guess_act == w_target_act) begin
               hint_d = C_HINT_OK;
               if (round_q == C_LAST_ROUND) begin
                  win_lose_d = C_WL_WIN;
                  state_d    = S_WIN;
               end else begin
                  state_d = S_RND_WON;
               end
            end else begin
               hint_d         = (w_guess_act < w_target_act) ? C_HINT_LOW : C_HINT_HIGH;
               guesses_left_d = w_guesses_dec;
               if (w_guesses_dec == 3'd0) begin
                  win_lose_d = C_WL_LOSE;
                  state_d    = S_LOSE;
               end else begin
                  state_d = S_PLAY;
               end
            end
         end
         S_RND_WON: begin
            if (confirm) begin
               round_d      = round_q + 2'd1;
               max_digits_d = (round_q == 2'd3) ? 2'd3 : round_q + 2'd1;
               state_d      = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      target_req_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         round_q        <= 2'd0;
         max_digits_q   <= 2'd0;
         guesses_left_q <= 3'd0;
         timer_q        <= 7'd0;
         hint_q         <= 2'd0;
         win_lose_q     <= 2'd0;
         target_req_q   <= 1'b0;
         target_q       <= 12'd0;
         guess_q        <= 12'd0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         max_digits_q   <= max_digits_d;
         guesses_left_q <= guesses_left_d;
         timer_q        <= timer_d;
         hint_q         <= hint_d;
         win_lose_q     <= win_lose_d;
         target_req_q   <= target_req_d;
         target_q       <= target_d;
         guess_q        <= guess_d;
      end
   end

   assign target_req   = target_req_q;
   assign max_digits   = max_digits_q;
   assign round        = round_q;
   assign guesses_left = guesses_left_q;
   assign timer        = timer_q;
   assign hint         = hint_q;
   assign win_lose     = win_lose_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// tb_game_sequencer : directed + randomized check of game_sequencer against a
// behavioural game model. Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module tb_game_sequencer;

   localparam int MAXG = 5;
   localparam int NR   = 3;
   localparam int T1   = 30;
   localparam int T2   = 60;
   localparam int T3   = 3;

   localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_PLAY = 3,
                  P_CHECK = 4, P_WON = 5, P_WIN = 6, P_LOSE = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, confirm = 1'b0, sec_tick = 1'b0, target_valid = 1'b0;
   logic [3:0] guess_d1 = '0, guess_d2 = '0, guess_d3 = '0;
   logic [3:0] target_d1 = '0, target_d2 = '0, target_d3 = '0;
   logic       target_req;
   logic [1:0] max_digits, round, w_hint, win_lose;
   logic [2:0] guesses_left;
   logic [6:0] timer;

   game_sequencer #(
      .MAX_GUESSES(MAXG), .NUM_ROUNDS(NR),
      .TIME_1D(T1), .TIME_2D(T2), .TIME_3D(T3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .confirm(confirm), .sec_tick(sec_tick),
      .guess_d1(guess_d1), .guess_d2(guess_d2), .guess_d3(guess_d3),
      .target_d1(target_d1), .target_d2(target_d2), .target_d3(target_d3),
      .target_valid(target_valid), .target_req(target_req),
      .max_digits(max_digits), .round(round), .guesses_left(guesses_left),
      .timer(timer), .hint(w_hint), .win_lose(win_lose)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference game: phase, counters and digits as plain integers.
   int m_ph = P_IDLE, m_round = 0, m_md = 0, m_gl = 0, m_timer = 0;
   int m_hint = 0, m_wl = 0, m_req = 0;
   int m_t[3] = '{0, 0, 0};
   int m_g[3] = '{0, 0, 0};

   function automatic int time_for(input int md);
      return (md == 1) ? T1 : (md == 2) ? T2 : T3;
   endfunction

   // Number formed by the active digits, most significant first, base 16
   // so out-of-range digits keep their raw weight.
   function automatic int number_of(input int d1, input int d2, input int d3, input int md);
      int d[3];
      int v;
      d[0] = d1; d[1] = d2; d[2] = d3;
      v = 0;
      for (int k = md - 1; k >= 0; k--) v = v * 16 + d[k];
      return v;
   endfunction

   task automatic model_step();
      int gv, tv;
      if (!rst) begin
         m_ph = P_IDLE; m_round = 0; m_md = 0; m_gl = 0; m_timer = 0;
         m_hint = 0; m_wl = 0;
         m_t = '{0, 0, 0};
         m_req = 0;
         return;
      end
      case (m_ph)
         P_IDLE, P_WIN, P_LOSE:
            if (start) begin
               m_round = 1; m_md = 1; m_wl = 0; m_hint = 0; m_ph = P_REQ;
            end
         P_REQ: m_ph = P_WAIT;
         P_WAIT:
            if (target_valid) begin
               m_t[0] = int'(target_d1); m_t[1] = int'(target_d2); m_t[2] = int'(target_d3);
               m_timer = time_for(m_md); m_gl = MAXG; m_hint = 0; m_ph = P_PLAY;
            end
         P_PLAY:
            if (sec_tick && m_timer == 1) begin
               m_timer = 0; m_wl = 2; m_ph = P_LOSE;
            end else begin
               if (sec_tick && m_timer > 0) m_timer = m_timer - 1;
               if (confirm) begin
                  m_g[0] = int'(guess_d1); m_g[1] = int'(guess_d2); m_g[2] = int'(guess_d3);
                  m_ph = P_CHECK;
               end
            end
         P_CHECK: begin
            gv = number_of(m_g[0], m_g[1], m_g[2], m_md);
            tv = number_of(m_t[0], m_t[1], m_t[2], m_md);
            if (gv == tv) begin
               m_hint = 3;
               if (m_round == NR) begin m_wl = 1; m_ph = P_WIN; end
               else m_ph = P_WON;
            end else begin
               m_hint = (gv < tv) ? 1 : 2;
               m_gl = m_gl - 1;
               if (m_gl == 0) begin m_wl = 2; m_ph = P_LOSE; end
               else m_ph = P_PLAY;
            end
         end
         P_WON:
            if (confirm) begin
               m_round = m_round + 1;
               m_md = (m_round > 3) ? 3 : m_round;
               m_ph = P_REQ;
            end
         default: m_ph = P_IDLE;
      endcase
      m_req = (m_ph == P_REQ) ? 1 : 0;
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_step();
      #1;
      check_val("target_req",   target_req,   m_req);
      check_val("max_digits",   max_digits,   m_md);
      check_val("round",        round,        m_round);
      check_val("guesses_left", guesses_left, m_gl);
      check_val("timer",        timer,        m_timer);
      check_val("hint",         w_hint,       m_hint);
      check_val("win_lose",     win_lose,     m_wl);
      start = 1'b0; confirm = 1'b0; sec_tick = 1'b0;
   endtask

   task automatic load_target(input int a, input int b, input int c);
      run_cycle();
      target_d1 = 4'(a); target_d2 = 4'(b); target_d3 = 4'(c);
      target_valid = 1'b1;
      run_cycle();
      target_valid = 1'b0;
   endtask

   task automatic new_game(input int a, input int b, input int c);
      start = 1'b1;
      run_cycle();
      load_target(a, b, c);
   endtask

   task automatic play_guess(input int a, input int b, input int c);
      guess_d1 = 4'(a); guess_d2 = 4'(b); guess_d3 = 4'(c);
      confirm = 1'b1;
      run_cycle();
      run_cycle();
   endtask

   task automatic next_round(input int a, input int b, input int c);
      confirm = 1'b1;
      run_cycle();
      load_target(a, b, c);
   endtask

   initial begin
      rst = 1'b0;
      run_cycle();
      run_cycle();
      check_val("reset_round", round, 0);
      rst = 1'b1;

      // Round 1, target 7; upper guess digits are garbage.
      start = 1'b1;
      run_cycle();
      check_val("req_pulse", target_req, 1);
      load_target(7, 0, 0);
      check_val("req_single", target_req, 0);
      check_val("r1_timer", timer, T1);
      check_val("r1_guesses", guesses_left, MAXG);
      play_guess(3, 15, 10);
      check_val("low_hint", w_hint, 1);
      check_val("low_gl", guesses_left, 4);
      play_guess(9, 3, 6);
      check_val("high_hint", w_hint, 2);
      check_val("high_gl", guesses_left, 3);
      play_guess(7, 9, 9);
      check_val("ok_hint", w_hint, 3);
      sec_tick = 1'b1;
      run_cycle();
      check_val("won_frozen", timer, T1);

      // Round 2, target 42, five misses.
      next_round(2, 4, 0);
      check_val("r2_round", round, 2);
      check_val("r2_md", max_digits, 2);
      check_val("r2_timer", timer, T2);
      for (int i = 0; i < 5; i++) play_guess((i % 2) ? 1 : 3, 4, 5);
      check_val("r2_gl0", guesses_left, 0);
      check_val("r2_lose", win_lose, 2);
      confirm = 1'b1; sec_tick = 1'b1;
      run_cycle();
      new_game(5, 0, 0);
      check_val("restart_round", round, 1);

      // Full win: 5, 42, 913.
      play_guess(5, 0, 0);
      next_round(2, 4, 0);
      play_guess(2, 4, 7);
      next_round(3, 1, 9);
      check_val("r3_timer", timer, T3);
      play_guess(3, 1, 9);
      check_val("win", win_lose, 1);
      for (int i = 0; i < 6; i++) begin
         confirm = i[0]; sec_tick = ~i[0];
         run_cycle();
      end

      // Timeout in round 3, final tick beats a same-cycle confirm.
      new_game(1, 0, 0);
      play_guess(1, 0, 0);
      next_round(1, 1, 0);
      play_guess(1, 1, 0);
      next_round(5, 5, 5);
      sec_tick = 1'b1; run_cycle();
      check_val("tick_2", timer, 2);
      sec_tick = 1'b1; run_cycle();
      check_val("tick_1", timer, 1);
      guess_d1 = 4'd5; guess_d2 = 4'd5; guess_d3 = 4'd5;
      sec_tick = 1'b1; confirm = 1'b1; run_cycle();
      check_val("timeout_lose", win_lose, 2);
      check_val("timeout_hint", w_hint, 0);
      run_cycle();

      // start ignored mid-PLAY; reset during CHECK.
      new_game(8, 0, 0);
      start = 1'b1; run_cycle();
      check_val("start_ignored", round, 1);
      guess_d1 = 4'd2; confirm = 1'b1; run_cycle();
      rst = 1'b0; run_cycle();
      check_val("rst_check_gl", guesses_left, 0);
      rst = 1'b1;

      // Randomized play.
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 199) != 0);
         start        = ($urandom_range(0, 24) == 0);
         confirm      = ($urandom_range(0, 3) == 0);
         sec_tick     = ($urandom_range(0, 2) == 0);
         target_valid = ($urandom_range(0, 2) == 0);
         target_d1 = 4'($urandom); target_d2 = 4'($urandom); target_d3 = 4'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            guess_d1 = 4'(m_t[0]); guess_d2 = 4'(m_t[1]); guess_d3 = 4'(m_t[2]);
            if ($urandom_range(0, 2) == 0) guess_d3 = 4'($urandom);
         end else begin
            guess_d1 = 4'($urandom); guess_d2 = 4'($urandom); guess_d3 = 4'($urandom);
         end
         run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
